// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and width defaults for the Data_Memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DEFAULT_DATA_W = 256;
    localparam int DEFAULT_ADDR_W = 32;

    typedef logic port_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pick
// Brief    : Combinational winner select; ARB_ROUND_ROBIN_EN picks round-robin
//            tie-breaking, otherwise port 0 always wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic      i_req0,
    input  logic      i_req1,
    input  port_idx_t i_prio,
    output logic      o_any,
    output port_idx_t o_winner
);

    assign o_any = i_req0 | i_req1;

`ifdef ARB_ROUND_ROBIN_EN
    // i_prio names the port that was not granted last
    always_comb begin
        o_winner = 1'b0;
        if (i_req0 && i_req1) begin
            o_winner = i_prio;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end
`else
    logic w_unused_prio;
    assign w_unused_prio = i_prio;
    assign o_winner      = !i_req0 && i_req1;
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares one Data_Memory port between icache (port 0) and dcache
//            (port 1). Tie-break mode selected by ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    state_t            r_state;
    port_idx_t         r_owner;
    port_idx_t         r_prio;
    logic              r_enable;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_any;
    port_idx_t         w_winner;
    logic              w_busy_ack;

    dmem_arb_pick u_pick (
        .i_req0   (m0_enable_i),
        .i_req1   (m1_enable_i),
        .i_prio   (r_prio),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_prio   <= 1'b0;
            r_enable <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= BUSY;
                        r_enable <= 1'b1;
                        r_owner  <= w_winner;
                        r_prio   <= ~w_winner;
                        r_write  <= w_winner ? m1_write_i : m0_write_i;
                        r_addr   <= w_winner ? m1_addr_i  : m0_addr_i;
                        r_data   <= w_winner ? m1_data_i  : m0_data_i;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        r_state  <= DONE;
                        r_enable <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    // Memory ack passes straight through, but only while a grant is live
    assign w_busy_ack   = (r_state == BUSY) && mem_ack_i;
    assign m0_ack_o     = w_busy_ack && (r_owner == 1'b0);
    assign m1_ack_o     = w_busy_ack && (r_owner == 1'b1);
    assign m0_data_o    = mem_data_i;
    assign m1_data_o    = mem_data_i;

    assign mem_enable_o = r_enable;
    assign mem_write_o  = r_write;
    assign mem_addr_o   = r_addr;
    assign mem_data_o   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         m0_enable_i = 1'b0, m0_write_i = 1'b0;
    logic [31:0]  m0_addr_i = '0;
    logic [255:0] m0_data_i = '0;
    logic         m0_ack_o;
    logic [255:0] m0_data_o;
    logic         m1_enable_i = 1'b0, m1_write_i = 1'b0;
    logic [31:0]  m1_addr_i = '0;
    logic [255:0] m1_data_i = '0;
    logic         m1_ack_o;
    logic [255:0] m1_data_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_data_i = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .m0_enable_i  (m0_enable_i),
        .m0_write_i   (m0_write_i),
        .m0_addr_i    (m0_addr_i),
        .m0_data_i    (m0_data_i),
        .m0_ack_o     (m0_ack_o),
        .m0_data_o    (m0_data_o),
        .m1_enable_i  (m1_enable_i),
        .m1_write_i   (m1_write_i),
        .m1_addr_i    (m1_addr_i),
        .m1_data_i    (m1_data_i),
        .m1_ack_o     (m1_ack_o),
        .m1_data_o    (m1_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns number of edges until mem_enable_o is seen high (capped at 20)
    task automatic wait_grant(output int cycles);
        cycles = 0;
        while (mem_enable_o !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", mem_enable_o); end
        checks++;
        if (mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", mem_write_o); end
        checks++;
        if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
        checks++;
        if (mem_data_o !== 256'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", mem_data_o); end
        mem_ack_i = 1'b1;
        #1;
        checks++;
        if ({m0_ack_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {m0_ack_o, m1_ack_o}); end
        mem_ack_i = 1'b0;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_fill();
        m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0400;
        tick();
        checks++;
        if (mem_enable_o !== 1'b1) begin errors++; $display("FAIL fill_enable: got %b expected 1", mem_enable_o); end
        checks++;
        if (mem_addr_o !== 32'h400) begin errors++; $display("FAIL fill_addr: got %h expected 400", mem_addr_o); end
        checks++;
        if (mem_write_o !== 1'b0) begin errors++; $display("FAIL fill_write: got %b expected 0", mem_write_o); end
        mem_ack_i = 1'b1; mem_data_i = 256'h5;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1) begin errors++; $display("FAIL fill_m0_ack: got %b expected 1", m0_ack_o); end
        checks++;
        if (m0_data_o !== 256'h5) begin errors++; $display("FAIL fill_m0_data: got %h expected 5", m0_data_o); end
        checks++;
        if (m1_ack_o !== 1'b0) begin errors++; $display("FAIL fill_m1_ack: got %b expected 0", m1_ack_o); end
        m0_enable_i = 1'b0;
        tick();
        mem_ack_i = 1'b0;
        checks++;
        if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL fill_done_enable: got %b expected 0", mem_enable_o); end
        tick();
    endtask

    task automatic test_arbitration();
        int n;
        logic got_port;
        logic exp_port [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_port = '{1'b0, 1'b1, 1'b0};
`else
        exp_port = '{1'b0, 1'b0, 1'b0};
`endif
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h100;
        m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h200;
        for (int g = 0; g < 3; g++) begin
            wait_grant(n);
            checks++;
            if (n != ((g == 0) ? 1 : 2)) begin errors++; $display("FAIL arb_gap%0d: got %0d expected %0d", g, n, (g == 0) ? 1 : 2); end
            got_port = (mem_addr_o == 32'h200);
            checks++;
            if (got_port !== exp_port[g]) begin errors++; $display("FAIL arb_owner%0d: got %b expected %b", g, got_port, exp_port[g]); end
            mem_ack_i = 1'b1; mem_data_i = 256'(g + 10);
            #1;
            checks++;
            if ({m1_ack_o, m0_ack_o} !== (exp_port[g] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL arb_ack%0d: got m1/m0 %b expected %b", g, {m1_ack_o, m0_ack_o}, exp_port[g] ? 2'b10 : 2'b01);
            end
            tick();
            mem_ack_i = 1'b0;
        end
        m0_enable_i = 1'b0;
        m1_enable_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_writeback_hold();
        int n;
        logic [255:0] a5;
        a5 = {32{8'hA5}};
        m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h0000_0020; m1_data_i = a5;
        wait_grant(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL wb_latency: got %0d expected 1", n); end
        checks++;
        if (mem_data_o !== a5) begin errors++; $display("FAIL wb_data: got %h expected %h", mem_data_o, a5); end
        m1_addr_i = 32'h40; m1_data_i = '0; m1_write_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({mem_enable_o, mem_write_o, mem_addr_o} !== {1'b1, 1'b1, 32'h20}) begin
                errors++;
                $display("FAIL wb_hold%0d: got en=%b wr=%b addr=%h expected en=1 wr=1 addr=20", k, mem_enable_o, mem_write_o, mem_addr_o);
            end
        end
        mem_ack_i = 1'b1;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o} !== 2'b10) begin errors++; $display("FAIL wb_ack: got m1/m0 %b expected 10", {m1_ack_o, m0_ack_o}); end
        m1_enable_i = 1'b0;
        tick();
        mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int n;
        m0_enable_i = 1'b1; m0_write_i = 1'b1; m0_addr_i = 32'h300; m0_data_i = 256'h33;
        wait_grant(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL rstbusy_latency: got %0d expected 1", n); end
        rst_i = 1'b1;
        m0_enable_i = 1'b0;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({mem_enable_o, mem_write_o, mem_addr_o} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rstbusy_outputs: got en=%b wr=%b addr=%h expected all 0", mem_enable_o, mem_write_o, mem_addr_o);
        end
        mem_ack_i = 1'b1;
        #1;
        checks++;
        if ({m0_ack_o, m1_ack_o} !== 2'b00) begin errors++; $display("FAIL rstbusy_stray_ack: got %b expected 00", {m0_ack_o, m1_ack_o}); end
        tick();
        mem_ack_i = 1'b0;
        checks++;
        if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL rstbusy_idle: got %b expected 0", mem_enable_o); end
        tick();
    endtask

    task automatic test_early_drop();
        int n;
        m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h80;
        wait_grant(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL drop_latency: got %0d expected 1", n); end
        tick();
        tick();
        m1_enable_i = 1'b0;
        tick();
        checks++;
        if ({mem_enable_o, mem_addr_o} !== {1'b1, 32'h80}) begin
            errors++;
            $display("FAIL drop_continue: got en=%b addr=%h expected en=1 addr=80", mem_enable_o, mem_addr_o);
        end
        mem_ack_i = 1'b1; mem_data_i = 256'h77;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o} !== 2'b10) begin errors++; $display("FAIL drop_ack: got m1/m0 %b expected 10", {m1_ack_o, m0_ack_o}); end
        checks++;
        if (m1_data_o !== 256'h77) begin errors++; $display("FAIL drop_data: got %h expected 77", m1_data_o); end
        tick();
        mem_ack_i = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_fill();
        test_arbitration();
        test_writeback_hold();
        test_reset_mid_busy();
        test_early_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
